xdma_finish_sender: RTL and testbench

Transmit side of the XDMA chain-write finish protocol. Accepts finish requests (destination address, DMA ID) from the finish manager of a middle or last hop, queues them, and issues each one as a single-beat AXI write carrying an `xdma_to_remote_finish_t` word to the previous hop. It waits for the write response and retries on error. It sits between the finish manager's `to_remote_finish` handshake and the XDMA AXI master port.

---
 rtl/xdma_pkg.sv | 34 +++
 rtl/xdma_finish_req_fifo.sv | 61 ++++++
 rtl/xdma_finish_sender.sv | 161 ++++++++++++++++
 tb/tb_xdma_finish_sender.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_pkg.sv
// Shared XDMA types: the finish word sent back to the previous hop, AXI
// response codes and the finish-sender state encoding.
package xdma_pkg;

  localparam int unsigned DmaIdWidth = 16;

  typedef struct packed {
    logic [15:0]           reserved;
    logic [DmaIdWidth-1:0] dma_id;
  } xdma_to_remote_finish_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    XDMA_FIN_IDLE  = 2'd0,
    XDMA_FIN_SEND  = 2'd1,
    XDMA_FIN_WAITB = 2'd2
  } xdma_finish_send_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    err = 1'b1;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/xdma_finish_req_fifo.sv
// Request FIFO for the finish sender; full/empty come straight from the
// registered count so the upstream ready never depends on this cycle's pop.
module xdma_finish_req_fifo
  import xdma_pkg::*;
#(
  parameter type         entry_t = logic,
  parameter int unsigned Depth   = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  entry_t          r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign w_pop   = pop_i && !empty_o;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/xdma_finish_sender.sv
// Sends queued chain-write finish notifications to the previous hop as
// single-beat AXI writes, one outstanding at a time, retrying on error.
//
// state  | meaning
// IDLE   | nothing in flight; launch head entry when FIFO non-empty
// SEND   | AW and/or W of the head entry still pending
// WAITB  | both beats accepted, waiting for the write response
module xdma_finish_sender
  import xdma_pkg::*;
#(
  parameter type         id_t         = logic,
  parameter type         addr_t       = logic,
  parameter type         data_t       = logic,
  parameter type         strb_t       = logic,
  parameter int unsigned Depth        = 2,
  parameter addr_t       FinishOffset = '0,
  parameter int unsigned MaxRetries   = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  addr_t      remote_addr_i,
  input  id_t        dma_id_i,
  input  logic       finish_valid_i,
  output logic       finish_ready_o,
  output addr_t      aw_addr_o,
  output logic       aw_valid_o,
  input  logic       aw_ready_i,
  output data_t      w_data_o,
  output strb_t      w_strb_o,
  output logic       w_last_o,
  output logic       w_valid_o,
  input  logic       w_ready_i,
  input  logic [1:0] b_resp_i,
  input  logic       b_valid_i,
  output logic       b_ready_o,
  output logic       busy_o,
  output logic       finish_error_o
);

  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  typedef struct packed {
    addr_t addr;
    id_t   dma_id;
  } req_t;

  req_t                    w_req_in;
  req_t                    w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  xdma_to_remote_finish_t  w_finish;

  xdma_finish_send_state_t r_state;
  xdma_finish_send_state_t w_state_nxt;
  logic                    r_aw_pend;
  logic                    w_aw_pend_nxt;
  logic                    r_w_pend;
  logic                    w_w_pend_nxt;
  logic [RetryW-1:0]       r_retry_cnt;
  logic [RetryW-1:0]       w_retry_nxt;
  logic                    r_err;
  logic                    w_err_nxt;

  assign w_req_in.addr   = remote_addr_i;
  assign w_req_in.dma_id = dma_id_i;
  assign finish_ready_o  = !w_full;
  assign w_push          = finish_valid_i && !w_full;

  xdma_finish_req_fifo #(
    .entry_t (req_t),
    .Depth   (Depth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_req_in),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Payload comes from the head entry, which stays put until its B returns,
  // so AW/W contents are stable across back-pressure and retries.
  always_comb begin
    w_finish        = '0;
    w_finish.dma_id = DmaIdWidth'(w_head.dma_id);
  end

  assign aw_addr_o = w_head.addr + FinishOffset;
  assign w_data_o  = data_t'(w_finish);
  assign w_strb_o  = '1;
  assign w_last_o  = 1'b1;

  assign aw_valid_o     = (r_state == XDMA_FIN_SEND) && r_aw_pend;
  assign w_valid_o      = (r_state == XDMA_FIN_SEND) && r_w_pend;
  assign b_ready_o      = (r_state == XDMA_FIN_WAITB);
  assign busy_o         = !w_empty || (r_state != XDMA_FIN_IDLE);
  assign finish_error_o = r_err;

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_pend_nxt = r_aw_pend;
    w_w_pend_nxt  = r_w_pend;
    w_retry_nxt   = r_retry_cnt;
    w_pop         = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      XDMA_FIN_IDLE: begin
        if (!w_empty) begin
          w_state_nxt   = XDMA_FIN_SEND;
          w_aw_pend_nxt = 1'b1;
          w_w_pend_nxt  = 1'b1;
          w_retry_nxt   = '0;
        end
      end
      XDMA_FIN_SEND: begin
        if (r_aw_pend && aw_ready_i) w_aw_pend_nxt = 1'b0;
        if (r_w_pend && w_ready_i)   w_w_pend_nxt  = 1'b0;
        if (!w_aw_pend_nxt && !w_w_pend_nxt) w_state_nxt = XDMA_FIN_WAITB;
      end
      XDMA_FIN_WAITB: begin
        if (b_valid_i) begin
          if (!resp_is_err(b_resp_i)) begin
            w_pop       = 1'b1;
            w_state_nxt = XDMA_FIN_IDLE;
          end else if (32'(r_retry_cnt) < MaxRetries) begin
            w_retry_nxt   = r_retry_cnt + RetryW'(1);
            w_aw_pend_nxt = 1'b1;
            w_w_pend_nxt  = 1'b1;
            w_state_nxt   = XDMA_FIN_SEND;
          end else begin
            w_pop       = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = XDMA_FIN_IDLE;
          end
        end
      end
      default: w_state_nxt = XDMA_FIN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= XDMA_FIN_IDLE;
      r_aw_pend   <= 1'b0;
      r_w_pend    <= 1'b0;
      r_retry_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_aw_pend   <= w_aw_pend_nxt;
      r_w_pend    <= w_w_pend_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_err       <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_xdma_finish_sender.sv
// Scoreboard bench for xdma_finish_sender: each accepted request expands into
// its expected AXI attempts; a negedge monitor pops and compares them.
module tb_xdma_finish_sender;
  import xdma_pkg::*;

  localparam int MAXR  = 2;
  localparam int DEPTH = 2;
  localparam logic [31:0] OFFS = 32'h40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_id = '0;
  int          req_k = 0;
  logic        finish_valid = 1'b0;
  logic        finish_ready_o;
  logic [31:0] aw_addr_o;
  logic        aw_valid_o;
  logic        aw_ready = 1'b1;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        w_last_o;
  logic        w_valid_o;
  logic        w_ready = 1'b1;
  logic [1:0]  b_resp = 2'b00;
  logic        b_valid = 1'b0;
  logic        b_ready_o;
  logic        busy_o;
  logic        finish_error_o;

  xdma_finish_sender #(
    .id_t         (logic [7:0]),
    .addr_t       (logic [31:0]),
    .data_t       (logic [63:0]),
    .strb_t       (logic [7:0]),
    .Depth        (DEPTH),
    .FinishOffset (OFFS),
    .MaxRetries   (MAXR)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .remote_addr_i  (req_addr),
    .dma_id_i       (req_id),
    .finish_valid_i (finish_valid),
    .finish_ready_o (finish_ready_o),
    .aw_addr_o      (aw_addr_o),
    .aw_valid_o     (aw_valid_o),
    .aw_ready_i     (aw_ready),
    .w_data_o       (w_data_o),
    .w_strb_o       (w_strb_o),
    .w_last_o       (w_last_o),
    .w_valid_o      (w_valid_o),
    .w_ready_i      (w_ready),
    .b_resp_i       (b_resp),
    .b_valid_i      (b_valid),
    .b_ready_o      (b_ready_o),
    .busy_o         (busy_o),
    .finish_error_o (finish_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] resp;
    bit         last;
    bit         drop;
  } bexp_t;

  logic [31:0] exp_aw[$];
  logic [63:0] exp_w[$];
  bexp_t       exp_b[$];
  int          cnt = 0;
  int          n_aw = 0, n_w = 0, n_b = 0;
  bit          exp_err = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          b_stall = 1'b0;
  int          total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (bound expired) at %0t", name, $time);
  endtask

  // Monitor and reference model: compare first, then fold in this cycle's handshakes.
  always @(negedge clk) begin
    bit    outst;
    bexp_t e;
    logic [31:0] ea;
    int    att;
    if (rst_n) begin
      outst = (n_aw > n_b) && (n_w > n_b);
      check("finish_ready", finish_ready_o, cnt < DEPTH);
      check("busy", busy_o, cnt != 0);
      check("finish_error", finish_error_o, exp_err);
      exp_err = 1'b0;
      check("b_ready", b_ready_o, outst);
      if (aw_valid_o) begin
        check("aw_legal", (n_aw == n_b) && (exp_aw.size() > 0), 1);
        if (exp_aw.size() > 0) check("aw_addr", aw_addr_o, exp_aw[0]);
      end
      if (w_valid_o) begin
        check("w_legal", (n_w == n_b) && (exp_w.size() > 0), 1);
        if (exp_w.size() > 0) check("w_data", w_data_o, exp_w[0]);
        check("w_strb", w_strb_o, 8'hFF);
        check("w_last", w_last_o, 1);
      end
      if (finish_valid && finish_ready_o) begin
        cnt++;
        ea  = req_addr + OFFS;
        att = (req_k > MAXR) ? MAXR + 1 : req_k + 1;
        for (int i = 0; i < att; i++) begin
          exp_aw.push_back(ea);
          exp_w.push_back(64'(req_id));
          e.last = (i == att - 1);
          e.drop = (req_k > MAXR) && e.last;
          if (i < req_k) e.resp = $urandom_range(0, 1) ? RESP_SLVERR : RESP_DECERR;
          else           e.resp = $urandom_range(0, 1) ? RESP_OKAY : RESP_EXOKAY;
          exp_b.push_back(e);
        end
      end
      if (aw_valid_o && aw_ready && n_aw == n_b && exp_aw.size() > 0) begin
        void'(exp_aw.pop_front());
        n_aw++;
      end
      if (w_valid_o && w_ready && n_w == n_b && exp_w.size() > 0) begin
        void'(exp_w.pop_front());
        n_w++;
      end
      if (b_valid && outst && exp_b.size() > 0) begin
        e = exp_b.pop_front();
        n_b++;
        if (e.last) begin
          cnt--;
          exp_err = e.drop;
        end
      end
    end
  end

  // AXI slave: random AW/W readiness, B returned with the scoreboard's chosen response.
  initial begin
    bit outst;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        aw_ready = ($urandom_range(0, 3) != 0);
        w_ready  = ($urandom_range(0, 3) != 0);
      end else begin
        aw_ready = 1'b1;
        w_ready  = 1'b1;
      end
      outst = (n_aw > n_b) && (n_w > n_b);
      if (!b_stall && rst_n && outst && exp_b.size() > 0 && $urandom_range(0, 2) != 0) begin
        b_valid = 1'b1;
        b_resp  = exp_b[0].resp;
      end else if (!b_stall && !outst && $urandom_range(0, 7) == 0) begin
        b_valid = 1'b1;
        b_resp  = 2'($urandom);
      end else begin
        b_valid = 1'b0;
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [7:0] id, input int k);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    req_addr     = a;
    req_id       = id;
    req_k        = k;
    finish_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (finish_ready_o) break;
      t++;
      if (t > 400) begin
        fail_now("push_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    finish_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (cnt != 0 || exp_b.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        fail_now(name);
        break;
      end
    end
  endtask

  int  ks[6] = '{0, 2, 3, 1, 3, 0};
  bit  p3_done;
  int  aw_seen;
  int  t;
  logic [31:0] a;

  initial begin
    // Reset values
    #12;
    check("rst_aw_valid", aw_valid_o, 0);
    check("rst_w_valid", w_valid_o, 0);
    check("rst_b_ready", b_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_finish_ready", finish_ready_o, 1);
    check("rst_finish_error", finish_error_o, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request: AW/W valid two cycles after the push
    push(32'h1000_0000, 8'd5, 0);
    @(negedge clk);
    check("lat_n1_aw_valid", aw_valid_o, 0);
    @(negedge clk);
    check("lat_n2_aw_valid", aw_valid_o, 1);
    check("lat_n2_w_valid", w_valid_o, 1);
    check("lat_n2_aw_addr", aw_addr_o, 32'h1000_0040);
    check("lat_n2_w_data", w_data_o, 64'd5);
    wait_drain("drain_single");

    // Full FIFO with B stalled: third push waits for the first B
    b_stall = 1'b1;
    push(32'h2000_0000, 8'd1, 0);
    push(32'h2000_0100, 8'd2, 0);
    p3_done = 1'b0;
    fork
      begin
        push(32'h2000_0200, 8'd3, 0);
        p3_done = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    check("full_ready_low", finish_ready_o, 0);
    check("full_p3_pending", p3_done, 0);
    b_stall = 1'b0;
    t = 0;
    while (!p3_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("full_p3_accepted", p3_done, 1);
    wait_drain("drain_full");

    // Randomized traffic with back-pressure, retries and drops
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      push(a, 8'($urandom), (i < 6) ? ks[i] : $urandom_range(0, MAXR + 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain("drain_random");
    rnd_ready = 1'b0;

    // Asynchronous reset while waiting for B with two entries queued
    b_stall = 1'b1;
    push(32'h3000_0000, 8'd7, 0);
    push(32'h3000_0100, 8'd8, 0);
    t = 0;
    while (!((n_aw > n_b) && (n_w > n_b)) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rstmid_in_waitb", b_ready_o, 1);
    check("rstmid_queued", cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_aw_valid", aw_valid_o, 0);
    check("rstmid_w_valid", w_valid_o, 0);
    check("rstmid_b_ready", b_ready_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_finish_ready", finish_ready_o, 1);
    check("rstmid_finish_error", finish_error_o, 0);
    exp_aw.delete();
    exp_w.delete();
    exp_b.delete();
    cnt = 0;
    n_aw = 0;
    n_w = 0;
    n_b = 0;
    exp_err = 1'b0;
    b_stall = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    aw_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (aw_valid_o || w_valid_o) aw_seen++;
    end
    check("post_rst_no_aw", aw_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
